ps2_code_lock: RTL and testbench

Parametrised PS/2 keyboard code lock: a generalised password terminal. Receives raw PS/2 frames from the keyboard pins, oversampled in the system clock domain. Validates framing and parity, and strips break and extended prefixes. Matches typed make codes against a PASS_LEN-entry password, with backspace, a retry limit and a timed lockout. Sits directly on the keyboard pins and drives the board LEDs and status lines.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_rx.sv | 82 ++++++++
 rtl/ps2_code_lock.sv | 165 ++++++++++++++++
 tb/tb_ps2_code_lock.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, frame length and lock FSM state type
// for the PS/2 code lock.
package ps2_pkg;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;
    localparam logic [7:0] BKSP  = 8'h66;
    localparam logic [7:0] ESC   = 8'h76;

    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ENTRY,
        UNLOCKED,
        LOCKOUT
    } lock_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit
// shift/check with odd parity, and an idle timeout inside a frame.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]            kclk_q;   // [0],[1] synchroniser, [2] previous value
    logic [1:0]            kdat_q;
    logic                  fall_q;
    logic                  bit_q;
    logic [3:0]            cnt_q;
    logic [FRAME_BITS-2:0] sh_q;     // start, data[7:0], parity once full
    logic [TW-1:0]         timer_q;
    logic [7:0]            code_q;
    logic                  valid_q;
    logic                  err_q;
    logic                  frame_ok;

    assign frame_ok = ~sh_q[0] & bit_q & (^sh_q[FRAME_BITS-2:1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kclk_q  <= '1;
            kdat_q  <= '1;
            fall_q  <= 1'b0;
            bit_q   <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= '0;
            timer_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            kclk_q  <= {kclk_q[1:0], kclk_i};
            kdat_q  <= {kdat_q[0], kdata_i};
            fall_q  <= kclk_q[2] & ~kclk_q[1];
            bit_q   <= kdat_q[1];
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (fall_q) begin
                timer_q <= '0;
                if (cnt_q == 4'(FRAME_BITS - 1)) begin
                    cnt_q <= '0;
                    if (frame_ok) begin
                        code_q  <= sh_q[8:1];
                        valid_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else begin
                    sh_q  <= {bit_q, sh_q[FRAME_BITS-2:1]};
                    cnt_q <= cnt_q + 4'd1;
                end
            end else if (cnt_q != '0) begin
                if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_q   <= 1'b1;
                    cnt_q   <= '0;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_code_lock.sv
// PS/2 password terminal: receiver, break/extended prefix decoder and
// lock FSM with backspace, retry limit and timed lockout.
module ps2_code_lock
    import ps2_pkg::*;
#(
    parameter int unsigned                   PASS_LEN       = 4,
    parameter logic [PASS_LEN-1:0][7:0]      PASSWORD       = 32'h2D_24_3C_2C,
    parameter int unsigned                   MAX_TRIES      = 3,
    parameter int unsigned                   LOCK_CYCLES    = 1000,
    parameter int unsigned                   TIMEOUT_CYCLES = 5000
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                keyboard_clk,
    input  logic                data,
    output logic [PASS_LEN-1:0] leds,
    output logic                unlocked,
    output logic                locked_out,
    output logic                frame_err,
    output logic [7:0]          code,
    output logic                code_valid
);

    localparam int unsigned IW  = $clog2(PASS_LEN + 1);
    localparam int unsigned TRW = $clog2(MAX_TRIES + 1);
    localparam int unsigned LW  = $clog2(LOCK_CYCLES + 1);

    lock_state_t       state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PASS_LEN-1:0] match_q, match_d;
    logic [TRW-1:0]      tries_q, tries_d, tries_n;
    logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
    logic                brk_q, mk_valid_q;
    logic [7:0]          mk_code_q;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_i       (sys_clk),
        .rst_i       (rst),
        .kclk_i      (keyboard_clk),
        .kdata_i     (data),
        .code_o      (code),
        .code_valid_o(code_valid),
        .frame_err_o (frame_err)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            brk_q      <= 1'b0;
            mk_valid_q <= 1'b0;
            mk_code_q  <= '0;
        end else begin
            mk_valid_q <= 1'b0;
            if (code_valid) begin
                if (brk_q) begin
                    brk_q <= 1'b0;
                end else if (code == BREAK) begin
                    brk_q <= 1'b1;
                end else if (code != EXT) begin
                    mk_valid_q <= 1'b1;
                    mk_code_q  <= code;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ENTRY;
            idx_q      <= '0;
            match_q    <= '0;
            tries_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            match_q    <= match_d;
            tries_q    <= tries_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // State transitions resolve first; a make code seen in the same cycle
    // is then applied against the post-transition state and counters.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        match_d    = match_q;
        tries_d    = tries_q;
        lock_cnt_d = lock_cnt_q;
        tries_n    = (tries_q == TRW'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;

        case (state_q)
            ENTRY: begin
                if (idx_q == IW'(PASS_LEN)) begin
                    if (&match_q) begin
                        state_d = UNLOCKED;
                    end else begin
                        idx_d   = '0;
                        match_d = '0;
                        tries_d = tries_n;
                        if (tries_n == TRW'(MAX_TRIES)) begin
                            state_d    = LOCKOUT;
                            lock_cnt_d = LW'(LOCK_CYCLES);
                        end
                    end
                end
            end
            LOCKOUT: begin
                lock_cnt_d = lock_cnt_q - 1'b1;
                if (lock_cnt_q <= LW'(1)) begin
                    state_d    = ENTRY;
                    tries_d    = '0;
                    lock_cnt_d = '0;
                end
            end
            default: ;
        endcase

        if (mk_valid_q) begin
            case (state_d)
                ENTRY: begin
                    if (mk_code_q == BKSP) begin
                        if (idx_d != '0) begin
                            idx_d = idx_d - 1'b1;
                            for (int unsigned i = 0; i < PASS_LEN; i++)
                                if (IW'(i) == idx_d) match_d[i] = 1'b0;
                        end
                    end else if (idx_d < IW'(PASS_LEN)) begin
                        for (int unsigned i = 0; i < PASS_LEN; i++)
                            if (IW'(i) == idx_d) match_d[i] = (mk_code_q == PASSWORD[i]);
                        idx_d = idx_d + 1'b1;
                    end
                end
                UNLOCKED: begin
                    if (mk_code_q == ESC) begin
                        state_d = ENTRY;
                        idx_d   = '0;
                        match_d = '0;
                        tries_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        leds       = '0;
        unlocked   = 1'b0;
        locked_out = 1'b0;
        case (state_q)
            ENTRY: begin
                for (int unsigned i = 0; i < PASS_LEN; i++)
                    leds[i] = (IW'(i) < idx_q);
            end
            UNLOCKED: begin
                leds     = '1;
                unlocked = 1'b1;
            end
            LOCKOUT:  locked_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_code_lock.sv
// Directed-plus-random bench for ps2_code_lock against a keystroke-level
// password model (queue of typed keys, try count, lock/unlock flags).
module tb_ps2_code_lock;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       keyboard_clk = 1'b1;
    logic       data = 1'b1;
    logic [3:0] leds;
    logic       unlocked, locked_out, frame_err, code_valid;
    logic [7:0] code;

    always #5 sys_clk = ~sys_clk;

    ps2_code_lock #(
        .PASS_LEN      (4),
        .PASSWORD      (32'h2D_24_3C_2C),
        .MAX_TRIES     (3),
        .LOCK_CYCLES   (1000),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .keyboard_clk(keyboard_clk),
        .data        (data),
        .leds        (leds),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .frame_err   (frame_err),
        .code        (code),
        .code_valid  (code_valid)
    );

    int unsigned cyc = 0, vcnt = 0, ecnt = 0, lock_cyc = 0;
    int unsigned last_v_cyc = 0, last_e_cyc = 0;
    logic [7:0]  last_code = 8'h00;
    int unsigned vectors = 0, fails = 0;
    int unsigned stop_cyc = 0, last_fall_cyc = 0, lk_snap = 0;

    logic [7:0] pw [4] = '{8'h2C, 8'h3C, 8'h24, 8'h2D};
    logic [7:0] typed [$];
    bit         m_brk = 0, m_unl = 0, m_lock = 0;
    int unsigned m_tries = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (code_valid) begin
            vcnt++;
            last_code  = code;
            last_v_cyc = cyc;
        end
        if (frame_err) begin
            ecnt++;
            last_e_cyc = cyc;
        end
        if (locked_out) lock_cyc++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_leds();
        if (m_unl)  return 4'hF;
        if (m_lock) return 4'h0;
        return 4'((1 << typed.size()) - 1);
    endfunction

    task automatic model_make(input logic [7:0] b);
        bit ok;
        if (m_lock) return;
        if (m_unl) begin
            if (b == 8'h76) begin
                m_unl = 0;
                typed.delete();
                m_tries = 0;
            end
            return;
        end
        if (b == 8'h66) begin
            if (typed.size() > 0) void'(typed.pop_back());
        end else begin
            typed.push_back(b);
            if (typed.size() == 4) begin
                ok = 1;
                for (int i = 0; i < 4; i++) if (typed[i] != pw[i]) ok = 0;
                typed.delete();
                if (ok) m_unl = 1;
                else begin
                    m_tries++;
                    if (m_tries == 3) begin
                        m_lock  = 1;
                        m_tries = 0;
                    end
                end
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_brk) m_brk = 0;
        else if (b == 8'hF0) m_brk = 1;
        else if (b != 8'hE0) model_make(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            data = f[i];
            repeat (4) @(negedge sys_clk);
            keyboard_clk  = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) stop_cyc = cyc;
            repeat (8) @(negedge sys_clk);
            keyboard_clk = 1'b1;
            repeat (4) @(negedge sys_clk);
        end
        data = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_leds"}, 32'(leds), 32'(exp_leds()));
        check({tag, "_unl"}, 32'(unlocked), 32'(m_unl));
        check({tag, "_lko"}, 32'(locked_out), 32'(m_lock));
    endtask

    task automatic send_key(input logic [7:0] b, input string tag);
        int unsigned v0;
        v0 = vcnt;
        if (!m_lock) lk_snap = lock_cyc;
        send_frame(b, 1'b0, 11);
        repeat (4) @(negedge sys_clk);
        check({tag, "_cv"}, vcnt - v0, 1);
        check({tag, "_code"}, 32'(last_code), 32'(b));
        model_byte(b);
        check_outputs(tag);
    endtask

    task automatic wait_lockout_end(input string tag);
        int n = 0;
        while (locked_out && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_released"}, 32'(locked_out), 0);
        check({tag, "_lock_len"}, lock_cyc - lk_snap, 1000);
        m_lock = 0;
        check_outputs({tag, "_after"});
    endtask

    function automatic logic [7:0] rnd_code();
        logic [7:0] r;
        do r = 8'($urandom_range(8'h01, 8'h83));
        while (r == 8'h66 || r == 8'h76 || r == 8'h2C);
        return r;
    endfunction

    initial begin
        logic [7:0] seq2 [6] = '{8'h2C, 8'h3C, 8'h66, 8'h3C, 8'h24, 8'h2D};
        int unsigned v0, e0, n;
        logic [7:0] k;

        repeat (4) @(negedge sys_clk);
        check("rst_leds", 32'(leds), 0);
        check("rst_unl", 32'(unlocked), 0);
        check("rst_lko", 32'(locked_out), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_code", 32'(code), 0);
        check("rst_cv", 32'(code_valid), 0);
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        for (int i = 0; i < 4; i++) begin
            send_key(pw[i], "t1_make");
            if (i == 0) check("cv_latency", last_v_cyc - stop_cyc, 4);
            send_key(8'hF0, "t1_brk");
            send_key(pw[i], "t1_rel");
        end
        send_key(8'h76, "t1_esc");

        foreach (seq2[i]) send_key(seq2[i], "t2");
        send_key(8'h76, "t2_esc");

        send_key(8'hE0, "ext_pfx");
        send_key(8'h2C, "ext_key");
        send_key(8'h66, "ext_bksp");

        for (int t = 0; t < 3; t++) begin
            send_key(rnd_code(), "wrong");
            for (int j = 0; j < 3; j++) send_key(8'($urandom_range(8'h01, 8'h83)), "wrong");
        end
        check("lock_model", 32'(m_lock), 1);
        send_key(8'h2C, "lk_ign");
        send_key(8'h3C, "lk_ign");
        wait_lockout_end("lk");
        for (int i = 0; i < 4; i++) send_key(pw[i], "post_lk");
        send_key(8'h76, "post_lk_esc");

        send_key(8'h2C, "par_pre");
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h2C, 1'b1, 11);
        repeat (4) @(negedge sys_clk);
        check("par_err", ecnt - e0, 1);
        check("par_cv", vcnt - v0, 0);
        check_outputs("par");
        send_key(8'h66, "par_bksp");

        e0 = ecnt;
        send_frame(8'h3C, 1'b0, 5);
        n = 0;
        while (ecnt == e0 && n < 6000) begin
            @(negedge sys_clk);
            n++;
        end
        check("to_err", ecnt - e0, 1);
        check("to_time", 32'((last_e_cyc - last_fall_cyc >= 5000) && (last_e_cyc - last_fall_cyc <= 5008)), 1);
        send_key(8'h2C, "to_next");
        send_key(8'h66, "to_bksp");

        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: k = pw[$urandom_range(0, 3)];
                4:       k = 8'h66;
                5:       k = 8'h76;
                6:       k = 8'hF0;
                7:       k = 8'hE0;
                default: k = rnd_code();
            endcase
            send_key(k, "rnd");
            if (m_lock) wait_lockout_end("rnd_lk");
        end

        if (m_unl) send_key(8'h76, "pre_rst_esc");
        send_key(8'h2C, "pre_rst");
        send_frame(8'h3C, 1'b0, 5);
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("mrst_leds", 32'(leds), 0);
        check("mrst_unl", 32'(unlocked), 0);
        check("mrst_lko", 32'(locked_out), 0);
        check("mrst_ferr", 32'(frame_err), 0);
        check("mrst_code", 32'(code), 0);
        check("mrst_cv", 32'(code_valid), 0);
        typed.delete();
        m_brk = 0;
        m_unl = 0;
        m_lock = 0;
        m_tries = 0;
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        e0 = ecnt;
        send_key(8'h2C, "post_rst");
        check("post_rst_err", ecnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
